// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framing constants, framer state enum and dibit helper
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [10:0] ETH_MIN_LEN     = 11'd60;
    localparam logic [10:0] ETH_MAX_LEN     = 11'd1514;
    localparam logic [5:0]  IFG_CLKS        = 6'd48;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } framer_state_t;

    // Dibit k of a byte; bytes go onto the wire LSB dibit first.
    function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/crc32_d2.sv
// rtl/crc32_d2.sv - reflected CRC32 next-state function consuming two bits per clock
module crc32_d2
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  din,
    output logic [31:0] crc_out
);

    // Two serial LFSR steps, din[0] first since it is the earlier bit on the wire.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 2; i++) begin
            if (crc_out[0] ^ din[i])
                crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
            else
                crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/rmii_tx_framer.sv
// rtl/rmii_tx_framer.sv - RMII transmit framer; FCS generation present when RMII_TX_FCS_EN is defined
module rmii_tx_framer
    import eth_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_start,
    input  logic [10:0] tx_len,
    input  logic [7:0]  tx_data,
    output logic        tx_req,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        rmii_txen,
    output logic [1:0]  rmii_txdata
);

    // state/idx/cnt/sreg describe the dibit currently on the wire.
    framer_state_t state;
    logic [1:0]    idx;
    logic [10:0]   cnt;
    logic [7:0]    sreg;
    logic [10:0]   len_q;
    logic [5:0]    ifg_cnt;

    framer_state_t nxt_state;
    logic [10:0]   nxt_cnt;
    logic [7:0]    nxt_byte;
    logic [1:0]    idx_n;
    logic          data_last;
    logic          pad_last;
    logic          frame_last_slot;

    assign idx_n     = idx + 2'd1;
    assign data_last = (cnt == len_q - 11'd1);
    assign pad_last  = (cnt == ETH_MIN_LEN - 11'd1);

`ifdef RMII_TX_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [1:0]  fcs_sel;

    assign fcs_sel         = cnt[1:0] + 2'd1;
    assign frame_last_slot = (state == S_FCS) && (cnt == 11'd3);

    crc32_d2 u_crc (
        .crc_in  (crc_q),
        .din     (rmii_txdata),
        .crc_out (crc_next)
    );

    // CRC accumulates every DATA/PAD dibit as it leaves; it is frozen during FCS.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            crc_q <= CRC32_INIT;
        else if (state == S_IDLE)
            crc_q <= CRC32_INIT;
        else if (state == S_DATA || state == S_PAD)
            crc_q <= crc_next;
    end
`else
    assign frame_last_slot = (state == S_DATA && data_last && len_q >= ETH_MIN_LEN) ||
                             (state == S_PAD && pad_last);
`endif

    // Slot-boundary decision: which state and byte follow the current byte slot.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 11'd1;
        nxt_byte  = 8'h00;
        case (state)
            S_PREAMBLE: begin
                if (cnt == 11'd6) begin
                    nxt_state = S_SFD;
                    nxt_cnt   = 11'd0;
                    nxt_byte  = SFD_BYTE;
                end else begin
                    nxt_byte = PREAMBLE_BYTE;
                end
            end
            S_SFD: begin
                nxt_cnt = 11'd0;
                if (len_q == 11'd0) begin
                    nxt_state = S_PAD;
                end else begin
                    nxt_state = S_DATA;
                    nxt_byte  = tx_data;
                end
            end
            S_DATA, S_PAD: begin
                if (state == S_DATA && !data_last) begin
                    nxt_byte = tx_data;
                end else if (state == S_DATA && len_q < ETH_MIN_LEN) begin
                    nxt_state = S_PAD;
                end else if (state == S_DATA || pad_last) begin
`ifdef RMII_TX_FCS_EN
                    nxt_state = S_FCS;
                    nxt_cnt   = 11'd0;
                    nxt_byte  = ~crc_next[7:0];
`else
                    nxt_state = S_IFG;
`endif
                end
            end
`ifdef RMII_TX_FCS_EN
            S_FCS: begin
                if (cnt == 11'd3)
                    nxt_state = S_IFG;
                else
                    nxt_byte = ~crc_q[{fcs_sel, 3'b000} +: 8];
            end
`endif
            default: ;
        endcase
    end

    // Framer FSM with registered RMII outputs, fetch requests and done pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            idx         <= 2'd0;
            cnt         <= 11'd0;
            sreg        <= 8'h00;
            len_q       <= 11'd0;
            ifg_cnt     <= 6'd0;
            tx_req      <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            rmii_txen   <= 1'b0;
            rmii_txdata <= 2'b00;
        end else begin
            tx_req  <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        state       <= S_PREAMBLE;
                        idx         <= 2'd0;
                        cnt         <= 11'd0;
                        sreg        <= PREAMBLE_BYTE;
                        len_q       <= (tx_len > ETH_MAX_LEN) ? ETH_MAX_LEN : tx_len;
                        tx_busy     <= 1'b1;
                        rmii_txen   <= 1'b1;
                        rmii_txdata <= dibit_of(PREAMBLE_BYTE, 2'd0);
                    end
                end
                S_IFG: begin
                    if (ifg_cnt == IFG_CLKS - 6'd1) begin
                        state   <= S_IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        ifg_cnt <= ifg_cnt + 6'd1;
                    end
                end
                default: begin
                    if (idx != 2'd3) begin
                        idx         <= idx_n;
                        rmii_txdata <= dibit_of(sreg, idx_n);
                        if (idx == 2'd1)
                            tx_req <= (state == S_SFD && len_q != 11'd0) ||
                                      (state == S_DATA && !data_last);
                        if (idx == 2'd2)
                            tx_done <= frame_last_slot;
                    end else begin
                        idx   <= 2'd0;
                        state <= nxt_state;
                        cnt   <= nxt_cnt;
                        sreg  <= nxt_byte;
                        if (nxt_state == S_IFG) begin
                            rmii_txen   <= 1'b0;
                            rmii_txdata <= 2'b00;
                            ifg_cnt     <= 6'd0;
                        end else begin
                            rmii_txdata <= dibit_of(nxt_byte, 2'd0);
                        end
                    end
                end
            endcase
        end
    end

endmodule
